// File: rtl/uart_byte_fifo_tx.sv
// uart_byte_fifo_tx
// Byte FIFO feeding an 8N1 UART transmitter. Bytes pushed with wr_en are
// queued (DEPTH entries) and sent back-to-back with no idle gap between
// frames. A push while full is dropped and latches the sticky overflow flag.
//
// Optional feature: define UART_PARITY_EN to insert an even-parity bit
// after data bit 7 (11-bit frames instead of 10-bit frames).
//
// Parameters
//   CLK_HZ  input clock frequency in Hz
//   BAUD    line bit rate; one bit lasts CLK_HZ/BAUD clocks (truncated)
//   DEPTH   FIFO capacity in bytes, power of two, 2..256
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts any frame, flushes FIFO
//   wr_en     push wr_data this cycle (ignored while rst is high)
//   wr_data   byte to transmit
//   ovf_clr   clears overflow (a coincident drop wins)
//   tx_line   serial output, idle high (registered)
//   busy      FIFO non-empty or frame in progress (registered)
//   full      FIFO holds DEPTH bytes (registered)
//   empty     FIFO holds no bytes (registered)
//   overflow  sticky: a byte was dropped (registered)
module uart_byte_fifo_tx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  output logic       tx_line,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int BW  = (DIV > 1) ? $clog2(DIV + 1) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [2:0]    state, state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef UART_PARITY_EN
  logic          par_bit;
`endif
  logic          push, drop, pop, bit_done;

  assign push     = wr_en && !full && !rst;
  assign drop     = wr_en && full && !rst;
  assign bit_done = (baud_cnt == BW'(DIV - 1));

  // Next-state and pop decision; a pop always coincides with entering START
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:   if (count != '0) begin
                pop       = 1'b1;
                state_nxt = START;
              end
      START:  if (bit_done) state_nxt = DATA;
      DATA:   if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end
      PARITY: if (bit_done) state_nxt = STOP;
      STOP:   if (bit_done) begin
                if (count != '0) begin
                  pop       = 1'b1;
                  state_nxt = START;
                end else begin
                  state_nxt = IDLE;
                end
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Control registers: FIFO bookkeeping, FSM, counters and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_line  <= 1'b1;
      busy     <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      busy  <= (count_nxt != '0) || (state_nxt != IDLE);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      // Baud counter restarts at every bit boundary and is parked in IDLE
      if (state == IDLE || bit_done) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + BW'(1);
      // Wraps 7 -> 0 after the last data bit, ready for the next frame
      if (state == DATA && bit_done) bit_cnt <= bit_cnt + 3'd1;
      if (pop) begin
        tx_line <= 1'b0;
      end else if (bit_done) begin
        case (state)
          START: tx_line <= shreg[0];
          DATA:  if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                   tx_line <= par_bit;
`else
                   tx_line <= 1'b1;
`endif
                 end else begin
                   tx_line <= shreg[1];
                 end
          default: tx_line <= 1'b1;
        endcase
      end
    end
  end

  // Data registers: storage and shift register carry no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
    if (pop && !rst) begin
      shreg <= mem[rd_ptr];
`ifdef UART_PARITY_EN
      par_bit <= even_parity(mem[rd_ptr]);
`endif
    end else if (state == DATA && bit_done) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo_tx.sv
module tb_uart_byte_fifo_tx;

`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int DIVC = 10;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       tx_line, busy, full, empty, overflow;

  int vectors = 0;
  int miscompares = 0;

  uart_byte_fifo_tx #(.CLK_HZ(1000), .BAUD(100), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx_line(tx_line), .busy(busy), .full(full), .empty(empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Waits for a start bit, then checks every one of the DIV samples of each
  // frame bit. Returns on the last sample of the stop bit.
  task automatic rx_frame(input string tag, input logic [7:0] b, input int exp_wait);
    int waited = 0;
    logic busy_ok = 1'b1;
    logic bit_ok;
    logic first_bad;
    while (tx_line !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start"}, {31'b0, tx_line}, 32'd0);
    if (exp_wait >= 0) check({tag, "_latency"}, waited, exp_wait);
    for (int i = 0; i < FB; i++) begin
      bit_ok = 1'b1;
      first_bad = frame_bit(b, i);
      for (int s = 0; s < DIVC; s++) begin
        if (!(i == 0 && s == 0)) @(negedge clk);
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (tx_line !== frame_bit(b, i) && bit_ok) begin
          bit_ok = 1'b0;
          first_bad = tx_line;
        end
      end
      check($sformatf("%s_bit%0d", tag, i), {31'b0, first_bad}, {31'b0, frame_bit(b, i)});
    end
    check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
  endtask

  task automatic quiet(input string tag, input int n);
    logic ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (tx_line !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx_line}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0x55
    push(8'h55);
    check("single_empty", {31'b0, empty}, 32'd0);
    check("single_busy0", {31'b0, busy}, 32'd1);
    rx_frame("single", 8'h55, 1);
    @(negedge clk);
    check("single_busy_end", {31'b0, busy}, 32'd0);
    check("single_tx_idle", {31'b0, tx_line}, 32'd1);
    check("single_empty_end", {31'b0, empty}, 32'd1);

    // Back-to-back 0x0D, 0x0A pushed in consecutive cycles
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h0D;
    @(negedge clk);
    wr_data = 8'h0A;
    @(negedge clk);
    wr_en = 1'b0;
    rx_frame("b2b0", 8'h0D, 0);
    rx_frame("b2b1", 8'h0A, 1);
    @(negedge clk);
    check("b2b_busy_end", {31'b0, busy}, 32'd0);

    // Overflow: six pushes into a 4-deep FIFO
    fork
      begin
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hA0;
        for (int i = 1; i < 6; i++) begin
          @(negedge clk);
          wr_data = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("ovf_set", {31'b0, overflow}, 32'd1);
        check("ovf_full", {31'b0, full}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", {31'b0, overflow}, 32'd0);
        check("ovf_full2", {31'b0, full}, 32'd1);
      end
      begin
        rx_frame("ovf0", 8'hA0, -1);
        for (int i = 1; i < 5; i++)
          rx_frame($sformatf("ovf%0d", i), 8'hA0 + 8'(i), 1);
      end
    join
    check("ovf_empty_end", {31'b0, empty}, 32'd1);
    quiet("ovf_no_sixth", 3 * FB * DIVC);

    // Reset during data bit 3 of 0xA3 with two bytes queued
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'hA3;
    @(negedge clk);
    wr_data = 8'hB1;
    @(negedge clk);
    wr_data = 8'hB2;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (42) @(negedge clk);
    check("mid_bit3", {31'b0, tx_line}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd1);
    check("mid_empty", {31'b0, empty}, 32'd0);
    rst = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hFF;
    @(negedge clk);
    check("mid_rst_tx", {31'b0, tx_line}, 32'd1);
    check("mid_rst_empty", {31'b0, empty}, 32'd1);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_full", {31'b0, full}, 32'd0);
    rst = 1'b0;
    wr_en = 1'b0;
    quiet("mid_no_frames", 3 * FB * DIVC);
    check("mid_empty_after", {31'b0, empty}, 32'd1);

`ifdef UART_PARITY_EN
    push(8'h07);
    rx_frame("par07", 8'h07, 1);
    push(8'h03);
    rx_frame("par03", 8'h03, 1);
    @(negedge clk);
    check("par_busy_end", {31'b0, busy}, 32'd0);
`endif

    // Pointer wrap: 12 bytes pushed as space allows
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          int guard = 0;
          @(negedge clk);
          wr_en = 1'b0;
          while (full === 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
          end
          wr_en = 1'b1;
          wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
      end
      begin
        for (int i = 0; i < 12; i++)
          rx_frame($sformatf("wrap%0d", i), 8'(i), -1);
      end
    join
    check("wrap_ovf", {31'b0, overflow}, 32'd0);
    quiet("wrap_idle", 2 * FB * DIVC);
    check("wrap_empty", {31'b0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
